// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream byte stage and the UART serializer.
// The upstream stage offers tx_data with tx_valid; the serializer accepts it while tx_ready is high.
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// txd is registered, so each output bit is prepared one cycle ahead from the next state.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_serializer_if.slave   tx_if,
    output logic                  txd,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            txd_q, txd_d;
    logic            wrap;

    assign wrap           = (cnt_q == CntMax);
    assign tx_if.tx_ready = (state_q == StIdle);
    assign busy           = ~tx_if.tx_ready;
    assign txd            = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (tx_if.tx_valid) begin
                    state_d = StStart;
                    shift_d = tx_if.tx_data;
                    par_d   = ^tx_if.tx_data;
                    idx_d   = 3'd0;
                    txd_d   = 1'b0;
                end
            end
            StStart: begin
                if (wrap) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (wrap) begin
                    if (idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            txd_d   = par_q;
                        end else begin
                            state_d = StStop;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // Shift register keeps the current bit at [0]; [1] is the next one out.
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (wrap) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
            StStop: begin
                if (wrap) begin
                    state_d = StIdle;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (legal range >= 2).
REQ-002 SHALL provide parameter PARITY_EN, default 0, 1 = append even-parity bit after data.
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port tx_data  input  8  byte to transmit, sampled on acceptance.
REQ-006 SHALL provide port tx_valid  input  1  byte offered by upstream byte stage.
REQ-007 SHALL provide port tx_ready  output  1  serializer can accept a byte this cycle.
REQ-008 SHALL provide port txd  output  1  serial line, idle high, registered.
REQ-009 SHALL provide port busy  output  1  frame in progress (start through stop bit).

Function
REQ-010 SHALL accept a byte on the rising edge where tx_valid=1 and tx_ready=1, latching tx_data into an internal shift register.
REQ-011 SHALL assert tx_ready only in state IDLE; tx_valid while tx_ready=0 SHALL be ignored with no side effect.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance, START->DATA, DATA->PARITY after bit 7 if PARITY_EN=1 else DATA->STOP, PARITY->STOP, STOP->IDLE.
REQ-013 SHALL drive txd=0 in START, data bits LSB first in DATA, even parity (XOR of the 8 latched bits) in PARITY, txd=1 in STOP and IDLE.
REQ-014 SHALL hold each bit on txd for exactly CLKS_PER_BIT cycles using a down/up bit-period counter of width clog2(CLKS_PER_BIT), wrapping to 0 at each bit boundary.
REQ-015 SHALL use a 3-bit bit index in DATA, advancing on each bit-period wrap, leaving DATA after index 7 completes.
REQ-016 SHALL drive the start bit in the cycle immediately after the acceptance edge (latency 1 cycle from acceptance to txd falling).
REQ-017 SHALL make the frame length 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with PARITY_EN=1), measured from first start-bit cycle to last stop-bit cycle.
REQ-018 SHALL return to IDLE and assert tx_ready in the cycle after the last stop-bit cycle; with tx_valid held high, consecutive frames SHALL be separated by exactly one idle (txd=1) cycle.
REQ-019 SHALL assert busy=1 in START, DATA, PARITY and STOP, busy=0 in IDLE; busy SHALL equal ~tx_ready at all times.
REQ-020 SHALL NOT alter the latched byte if tx_data changes after acceptance.

Reset
REQ-021 SHALL, while reset=1, force state=IDLE, txd=1, tx_ready=1, busy=0, counters=0, shift register=0, independent of clk.
REQ-022 SHALL, on reset asserted mid-frame, abort the frame immediately (txd=1 asynchronously), discard the byte, and not resume it after reset release.
REQ-023 SHALL accept a new byte on the first rising edge after reset deassertion where tx_valid=1.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-024 Reset pulse with tx_valid=1 -> during reset txd=1, tx_ready=1, busy=0; no frame starts until reset released.
REQ-025 Send 0xA5, PARITY_EN=0 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles total, tx_ready high again on cycle 41 after acceptance.
REQ-026 tx_valid held high with 0x55 then 0x0F -> two correct frames, exactly one txd=1 idle cycle between them, tx_ready high exactly in that cycle.
REQ-027 Mid-frame tx_valid pulse with 0xFF while tx_ready=0 -> ongoing frame bits unchanged, 0xFF never transmitted.
REQ-028 PARITY_EN=1, send 0x07 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1(stop), 44 cycles total.
REQ-029 Reset asserted during data bit 3 of 0xC3 -> txd=1 same cycle, busy=0; after release, 0x3C sent and received bit-exact.
